// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - frame serializer that emits a parallel word MSB first and counts overlapping "101" patterns
// Frames are separated by at least two zero bits, so a per-frame history matches a free-running detector.
module seq_tx #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    output logic             Ready,
    output logic             X,
    output logic             Valid,
    output logic             Done,
    output logic [3:0]       Hits
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        DONE  = 3'b100
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nx;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nx;
    logic [1:0]     hist;
    logic [1:0]     hist_nx;
    logic [3:0]     hits_nx;
    logic           msb;

    assign msb = sr[WIDTH-1];

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            hist  <= '0;
            Hits  <= '0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
            hist  <= hist_nx;
            Hits  <= hits_nx;
        end
    end

    // X is taken from the shift-register MSB only, so it never follows Data/Start combinationally.
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        hist_nx  = hist;
        hits_nx  = Hits;
        Ready    = 1'b0;
        Valid    = 1'b0;
        X        = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                Ready = 1'b1;
                if (Start) begin
                    sr_nx    = Data;
                    cnt_nx   = CW'(WIDTH - 1);
                    hist_nx  = 2'b00;
                    hits_nx  = 4'd0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                Valid   = 1'b1;
                X       = msb;
                sr_nx   = {sr[WIDTH-2:0], 1'b0};
                cnt_nx  = cnt - 1'b1;
                hist_nx = {hist[0], msb};
                if (({hist, msb} == 3'b101) && (Hits != 4'd15)) begin
                    hits_nx = Hits + 4'd1;
                end
                if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_tx.sv
// tb/tb_seq_tx.sv - randomized scoreboard bench for seq_tx with a cycle-timing model and a free-running "101" detector
module tb_seq_tx;

    localparam int WIDTH = 8;

    logic             Clk   = 1'b0;
    logic             Clr   = 1'b1;
    logic             Start = 1'b0;
    logic [WIDTH-1:0] Data  = '0;
    logic             Ready;
    logic             X;
    logic             Valid;
    logic             Done;
    logic [3:0]       Hits;

    int errors = 0;
    int checks = 0;

    // Reference model: cycles remaining in the current frame (0 = idle).
    int               busy      = 0;
    logic [WIDTH-1:0] cur_data  = '0;
    int               last_hits = 0;
    int               exp_q[$];

    logic [2:0] det_hist  = 3'b000;
    int         det_cnt   = 0;
    int         done_seen = 0;

    seq_tx #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .Start (Start),
        .Data  (Data),
        .Ready (Ready),
        .X     (X),
        .Valid (Valid),
        .Done  (Done),
        .Hits  (Hits)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_hits(input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        for (int i = WIDTH - 1; i >= 2; i--) begin
            if (d[i] && !d[i-1] && d[i-2]) n++;
        end
        return (n > 15) ? 15 : n;
    endfunction

    // A frame occupies WIDTH shift cycles plus one done cycle after the accepting edge.
    always @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            busy      = 0;
            last_hits = 0;
            det_hist  = 3'b000;
            det_cnt   = 0;
            exp_q.delete();
        end else if (busy > 0) begin
            busy--;
        end else if (Start) begin
            cur_data  = Data;
            busy      = WIDTH + 1;
            last_hits = ref_hits(Data);
            exp_q.push_back(ref_hits(Data));
        end
    end

    always @(negedge Clk) begin
        int exp_x;
        int e;
        exp_x = (busy >= 2) ? int'(cur_data[busy-2]) : 0;
        check("ready", int'(Ready), int'(busy == 0));
        check("valid", int'(Valid), int'(busy >= 2));
        check("done",  int'(Done),  int'(busy == 1));
        check("x",     int'(X),     exp_x);
        if (busy == 0) check("hits_idle", int'(Hits), last_hits);
        if (!Clr) begin
            det_hist = {det_hist[1:0], X};
            if (det_hist == 3'b101) det_cnt++;
        end
        if (Done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("hits_done", int'(Hits), e);
                check("detector_vs_hits", det_cnt, int'(Hits));
            end
            det_cnt = 0;
        end
    end

    task automatic send_frame(input logic [WIDTH-1:0] d, input int exp_hits);
        int n;
        n = 0;
        while (busy != 0 && n < 100) begin
            @(negedge Clk);
            #1;
            n++;
        end
        check("idle_timeout", int'(busy == 0), 1);
        Data  = d;
        Start = 1'b1;
        @(negedge Clk);
        #1;
        Start = 1'b0;
        Data  = WIDTH'($urandom);
        repeat (WIDTH + 1) @(negedge Clk);
        #1;
        check("ready_after_frame", int'(Ready), 1);
        if (exp_hits >= 0) check("hits_directed", int'(Hits), exp_hits);
    endtask

    initial begin
        int d0;
        #7;
        check("rst_ready", int'(Ready), 1);
        check("rst_valid", int'(Valid), 0);
        check("rst_x",     int'(X),     0);
        check("rst_done",  int'(Done),  0);
        check("rst_hits",  int'(Hits),  0);
        @(negedge Clk);
        #1;
        Clr = 1'b0;

        send_frame(8'b10101010, 3);
        send_frame(8'b01011010, 2);
        send_frame(8'hFF, 0);
        send_frame(8'h00, 0);
        repeat (5) @(negedge Clk);
        #1;
        check("hits_hold_zero", int'(Hits), 0);

        // Abort a frame while its 4th bit is on X.
        Data  = 8'b10110101;
        Start = 1'b1;
        @(negedge Clk);
        #1;
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        check("pre_abort_valid", int'(Valid), 1);
        Clr = 1'b1;
        #1;
        check("abort_x",     int'(X),     0);
        check("abort_valid", int'(Valid), 0);
        check("abort_ready", int'(Ready), 1);
        check("abort_hits",  int'(Hits),  0);
        @(negedge Clk);
        #1;
        Clr = 1'b0;
        send_frame(8'b10101010, 3);

        // Start held high: back-to-back frames every WIDTH+2 cycles.
        d0 = done_seen;
        Start = 1'b1;
        repeat (3 * (WIDTH + 2)) begin
            @(negedge Clk);
            #1;
            Data = WIDTH'($urandom);
        end
        Start = 1'b0;
        check("held_start_frames", done_seen - d0, 3);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            #1;
            send_frame(WIDTH'($urandom), -1);
        end

        repeat (WIDTH + 4) @(negedge Clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 The block SHALL expose the following parameter: WIDTH, default 8, frame length in bits (min 3).
REQ-002 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on posedge.
REQ-003 The block SHALL have port Clr, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1 bit: request to send one frame; accepted only when Ready=1.
REQ-005 The block SHALL have port Data, input, WIDTH bits: parallel frame, sampled on the accepting edge.
REQ-006 The block SHALL have port Ready, output, 1 bit: high only in IDLE.
REQ-007 The block SHALL have port X, output, 1 bit: serial bit stream to the sequence detector, MSB first.
REQ-008 The block SHALL have port Valid, output, 1 bit: high while X carries a frame bit.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle pulse after the last bit.
REQ-010 The block SHALL have port Hits, output, 4 bits: count of "101" occurrences (overlapping) in the last frame.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT and DONE, with one-hot encoding.
REQ-012 In IDLE, the block SHALL drive Ready=1, Valid=0, X=0 and Done=0, and Hits SHALL hold its last value.
REQ-013 In IDLE, a posedge with Start=1 SHALL load Data into the shift register, load the bit counter with WIDTH-1, clear Hits and history to 0, and go to SHIFT.
REQ-014 In SHIFT, X SHALL equal shift-register MSB (registered, no combinational path from Data/Start), Valid SHALL be 1 and Ready SHALL be 0.
REQ-015 On each posedge in SHIFT, the block SHALL shift the register left by 1, decrement the counter, and shift X into the 2-bit history.
REQ-016 On each posedge in SHIFT, the block SHALL increment Hits when {history, X} == 3'b101; Hits SHALL saturate at 15.
REQ-017 On the SHIFT posedge with counter == 0, the block SHALL go to DONE; exactly WIDTH bits SHALL be emitted on the WIDTH cycles following acceptance.
REQ-018 DONE SHALL last exactly one cycle with Done=1, Valid=0, X=0 and Ready=0, and the next state SHALL be IDLE unconditionally.
REQ-019 In SHIFT or DONE, Start SHALL be ignored without queuing; the earliest next acceptance is the first IDLE cycle, giving a minimum inter-frame gap of 2 X=0 cycles.
REQ-020 The 2-bit history SHALL be cleared per frame; because frames are separated by at least 2 zero bits, Hits SHALL equal the Z=1 count of a continuously running "101" detector fed by X.
REQ-021 An illegal state encoding SHALL cause a transition to IDLE on the next posedge.

Reset
REQ-022 Clr=1 SHALL immediately force IDLE, Ready=1, X=0, Valid=0, Done=0, Hits=0, shift register 0, counter 0 and history 0, regardless of the clock.
REQ-023 Clr asserted mid-frame SHALL abort the frame without a Done pulse; after release, the next Start SHALL begin a fresh frame.
REQ-024 The block SHALL come out of power-up in the Clr state.

Verification
REQ-025 The bench SHALL cover: WIDTH=8, Data=8'b10101010, Start 1 cycle -> X=1,0,1,0,1,0,1,0 with Valid=1 over cycles 1..8, Done=1 at cycle 9, Hits=3, Ready=1 at cycle 10.
REQ-026 The bench SHALL cover: Data=8'b01011010 -> X=0,1,0,1,1,0,1,0, Hits=2.
REQ-027 The bench SHALL cover: Data=8'hFF -> X all 1, Hits=0; then Data=8'h00 -> Hits=0, with Hits holding 0 in IDLE.
REQ-028 The bench SHALL cover: Clr pulse during the 4th bit of a frame -> X=0, Valid=0, Ready=1 and Hits=0 asynchronously, no Done, and the next frame correct.
REQ-029 The bench SHALL cover: Start held high continuously -> frames every WIDTH+2 cycles, Start ignored in SHIFT/DONE, and X gaps of exactly 2 zeros.
REQ-030 The bench SHALL cover: seq_tx X driving a fsm detector with a shared Clk/Clr over random frames -> detector Z-high count per frame equals Hits.
